// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Function : Round-robin sharing of one 32-bit ALU between NREQ requesters,
//            with a single registered, id-tagged response slot.
//            Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_op1,
    input  logic [NREQ*32-1:0]   req_op2,
    input  logic [NREQ*3-1:0]    req_aluop,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          alu_op1,
    output logic [31:0]          alu_op2,
    output logic [2:0]           alu_aluop,
    input  logic [31:0]          alu_out,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_zero,
    input  logic                 rsp_ready
);

    logic           can_issue;
    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] grant_sel;
    int             grant_idx;

    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q,    rsp_id_d;
    logic [31:0]    rsp_data_q,  rsp_data_d;
    logic           rsp_zero_q,  rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDW-1:0] last_grant_q, last_grant_d;
`endif

    // A full slot may only be refilled in the cycle it is being drained.
    assign can_issue = !rsp_valid_q || rsp_ready;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        grant_idx = 0;
        grant_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_idx = k;
`else
            grant_idx = (int'(last_grant_q) + 1 + k) % NREQ;
`endif
            grant_sel = IDW'(grant_idx);
            if (!grant_any && req_valid[grant_sel]) begin
                grant_any = 1'b1;
                grant_id  = grant_sel;
            end
        end
        if (!rst_n || !can_issue) begin
            grant_any = 1'b0;
            grant_id  = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        alu_op1   = '0;
        alu_op2   = '0;
        alu_aluop = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any && grant_id == IDW'(i)) begin
                req_ready[i] = 1'b1;
                alu_op1      = req_op1[32*i +: 32];
                alu_op2      = req_op2[32*i +: 32];
                alu_aluop    = req_aluop[3*i +: 3];
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        if (grant_any) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_id;
            rsp_data_d  = alu_out;
            rsp_zero_d  = alu_zero;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_d = grant_id;
`endif
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= IDW'(NREQ - 1);
`endif
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

endmodule
`default_nettype wire
